// File: rtl/inval_line_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : inval_line_if
// Description : Valid/ready invalidation-address stream. The master drives
//               the address and valid, the slave returns ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface inval_line_if #(
  parameter int unsigned AddrWidth = 64
);
  logic [AddrWidth-1:0] addr;
  logic                 valid;
  logic                 ready;

  modport master (output addr, output valid, input  ready);
  modport slave  (input  addr, input  valid, output ready);
endinterface
`default_nettype wire

// File: rtl/inval_line_queue.sv
`default_nettype none
// ============================================================================
// Module      : inval_line_queue
// Description : Line-granular invalidation FIFO. Aligns each incoming address
//               to a D-cache line, drops a request that repeats the line most
//               recently queued, and buffers up to Depth distinct lines.
// Revision    : 1.0 - initial release
// ============================================================================
module inval_line_queue #(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16,
  parameter int unsigned Depth       = 4,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  inval_line_if.slave         in_if,
  inval_line_if.master        out_if,
  output logic                empty_o,
  output logic [CntWidth-1:0] drop_cnt_o
);

  localparam int unsigned          c_PTR_W     = $clog2(Depth);
  localparam logic [AddrWidth-1:0] c_LINE_MASK = ~(AddrWidth'(L1LineWidth - 1));
  localparam logic [c_PTR_W:0]     c_DEPTH     = (c_PTR_W + 1)'(Depth);
  localparam logic [c_PTR_W:0]     c_ONE       = (c_PTR_W + 1)'(1);

  logic [AddrWidth-1:0] r_mem [Depth];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_count;
  logic [AddrWidth-1:0] r_last_line;
  logic                 r_last_vld;
  logic [CntWidth-1:0]  r_drop_cnt;

  logic [AddrWidth-1:0] w_line;
  logic                 w_tail_match;
  logic                 w_pop;
  logic                 w_hit;
  logic                 w_in_ready;
  logic                 w_push;
  logic                 w_drop;

  // Line alignment, tail compare and handshake decode.
  // Input ready uses the tail match without the drain term: the drain term
  // only matters at count==1, where the queue is never full, so ready carries
  // no path from the downstream ready.
  always_comb begin
    w_line       = in_if.addr & c_LINE_MASK;
    w_tail_match = r_last_vld && (w_line == r_last_line);
    w_pop        = (r_count != '0) && out_if.ready;
    w_hit        = w_tail_match && !((r_count == c_ONE) && w_pop);
    w_in_ready   = en_i ? ((r_count < c_DEPTH) || w_tail_match) : 1'b1;
    w_push       = in_if.valid && w_in_ready && en_i && !w_hit;
    w_drop       = in_if.valid && w_in_ready && en_i && w_hit;
  end

  // Storage, pointers, occupancy and tail tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_line <= '0;
      r_last_vld  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_line;
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
        r_last_line     <= w_line;
        r_last_vld      <= 1'b1;
      end else if (w_pop && (r_count == c_ONE)) begin
        r_last_vld <= 1'b0;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating count of duplicate-line drops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + CntWidth'(1);
    end
  end

  // Output drive straight from state.
  always_comb begin
    in_if.ready  = w_in_ready;
    out_if.valid = (r_count != '0);
    out_if.addr  = r_mem[r_rd_ptr];
    empty_o      = (r_count == '0);
    drop_cnt_o   = r_drop_cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_inval_line_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_inval_line_queue
// Description : Directed bench for inval_line_queue with a queue-based
//               reference model and a per-cycle output comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inval_line_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        empty;
  logic [15:0] drop;
  logic        empty2;
  logic [1:0]  drop2;

  int errors = 0;
  int checks = 0;

  inval_line_if #(.AddrWidth(64)) in_if ();
  inval_line_if #(.AddrWidth(64)) out_if ();
  inval_line_if #(.AddrWidth(64)) in2 ();
  inval_line_if #(.AddrWidth(64)) out2 ();

  inval_line_queue #(.AddrWidth(64), .L1LineWidth(16), .Depth(4), .CntWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en),
    .in_if(in_if.slave), .out_if(out_if.master),
    .empty_o(empty), .drop_cnt_o(drop)
  );

  inval_line_queue #(.AddrWidth(64), .L1LineWidth(16), .Depth(4), .CntWidth(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .en_i(1'b1),
    .in_if(in2.slave), .out_if(out2.master),
    .empty_o(empty2), .drop_cnt_o(drop2)
  );

  always #5 clk = ~clk;

  // Reference model: the queue contents in arrival order plus a drop count.
  logic [63:0] mq[$];
  int unsigned m_drop = 0;

  function automatic logic [63:0] line_of(input logic [63:0] a);
    return {a[63:4], 4'h0};
  endfunction

  function automatic bit m_pop();
    return (mq.size() != 0) && out_if.ready;
  endfunction

  function automatic bit m_hit();
    return (mq.size() != 0) && (mq[$] == line_of(in_if.addr)) && !(mq.size() == 1 && m_pop());
  endfunction

  function automatic bit m_ready();
    return !en || (mq.size() < 4) || m_hit();
  endfunction

  task automatic model_step();
    bit pop, hit, acc;
    pop = m_pop();
    hit = m_hit();
    acc = in_if.valid && m_ready();
    if (pop) void'(mq.pop_front());
    if (acc && en) begin
      if (hit) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        mq.push_back(line_of(in_if.addr));
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit e, input bit v, input logic [63:0] a, input bit r);
    en           = e;
    in_if.valid  = v;
    in_if.addr   = a;
    out_if.ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic push_hold(input logic [63:0] a);
    drive(1'b1, 1'b1, a, 1'b0);
    tick();
  endtask

  task automatic drain_expect(input logic [63:0] exp);
    drive(1'b1, 1'b0, 64'h0, 1'b1);
    #1;
    check("order_valid", out_if.valid, 1'b1);
    check("order_addr", out_if.addr, exp);
    tick();
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", out_if.valid, mq.size() != 0);
      check("empty", empty, mq.size() == 0);
      check("ready", in_if.ready, m_ready());
      check("drop_cnt", drop, m_drop);
      if (mq.size() != 0) check("addr", out_if.addr, mq[0]);
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    in2.valid  = 1'b0;
    in2.addr   = 64'h0;
    out2.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_if.valid, 1'b0);
    check("rst_addr", out_if.addr, 64'h0);
    check("rst_empty", empty, 1'b1);
    check("rst_ready", in_if.ready, 1'b1);
    check("rst_drop", drop, 16'd0);
    rst_n = 1'b1;

    // Basic latency
    drive(1'b1, 1'b1, 64'h1234, 1'b1);
    tick();
    drive(1'b1, 1'b0, 64'h0, 1'b1);
    #1;
    check("lat_valid", out_if.valid, 1'b1);
    check("lat_addr", out_if.addr, 64'h1230);
    tick();
    check("lat_empty", empty, 1'b1);

    // Tail dedup
    drive(1'b1, 1'b1, 64'h1000, 1'b0); #1; check("dd_ready0", in_if.ready, 1'b1); tick();
    drive(1'b1, 1'b1, 64'h1008, 1'b0); #1; check("dd_ready1", in_if.ready, 1'b1); tick();
    drive(1'b1, 1'b1, 64'h100F, 1'b0); #1; check("dd_ready2", in_if.ready, 1'b1); tick();
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    #1;
    check("dd_drop", drop, 16'd2);
    check("dd_addr", out_if.addr, 64'h1000);
    drain_expect(64'h1000);
    check("dd_empty", empty, 1'b1);

    // Full with hit
    push_hold(64'h00);
    push_hold(64'h10);
    push_hold(64'h20);
    push_hold(64'h30);
    drive(1'b1, 1'b1, 64'h40, 1'b0); #1; check("full_ready", in_if.ready, 1'b0); tick();
    drive(1'b1, 1'b1, 64'h38, 1'b0); #1; check("hit_ready", in_if.ready, 1'b1); tick();
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    #1;
    check("hit_drop", drop, 16'd3);
    drain_expect(64'h00);
    push_hold(64'h40);
    drain_expect(64'h10);
    drain_expect(64'h20);
    drain_expect(64'h30);
    drain_expect(64'h40);
    check("full_empty", empty, 1'b1);

    // Non-tail repeat and drain corner
    push_hold(64'h10);
    push_hold(64'h20);
    push_hold(64'h10);
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    #1;
    check("nt_drop", drop, 16'd3);
    drain_expect(64'h10);
    drain_expect(64'h20);
    drain_expect(64'h10);
    push_hold(64'h50);
    drive(1'b1, 1'b1, 64'h54, 1'b1); #1; check("corner_ready", in_if.ready, 1'b1); tick();
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    #1;
    check("corner_valid", out_if.valid, 1'b1);
    check("corner_addr", out_if.addr, 64'h50);
    check("corner_drop", drop, 16'd3);
    drain_expect(64'h50);

    // Disable
    push_hold(64'h100);
    push_hold(64'h200);
    drive(1'b0, 1'b1, 64'h500, 1'b0); #1; check("dis_ready", in_if.ready, 1'b1); tick();
    drain_expect(64'h100);
    drain_expect(64'h200);
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    #1;
    check("dis_empty", empty, 1'b1);
    check("dis_drop", drop, 16'd3);
    tick();

    // Reset mid-operation
    push_hold(64'h600);
    push_hold(64'h700);
    push_hold(64'h800);
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    #1;
    rst_n = 1'b0;
    mq.delete();
    m_drop = 0;
    #1;
    check("arst_valid", out_if.valid, 1'b0);
    check("arst_empty", empty, 1'b1);
    check("arst_drop", drop, 16'd0);
    check("arst_addr", out_if.addr, 64'h0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 64'h0, 1'b1);
    repeat (3) tick();
    check("post_rst_valid", out_if.valid, 1'b0);

    // Drop counter saturation on the narrow-counter instance
    in2.addr   = 64'h77;
    in2.valid  = 1'b1;
    out2.ready = 1'b0;
    repeat (6) tick();
    in2.valid = 1'b0;
    #1;
    check("sat_drop", drop2, 2'd3);
    check("sat_empty", empty2, 1'b0);
    check("sat_addr", out2.addr, 64'h70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inval_line_queue.md
# inval_line_queue

Line-granular invalidation queue between the AXI invalidation filter's `inval_addr/inval_valid/inval_ready` output and the CVA6 accelerator-response invalidation fields packed in `ara_system`. It aligns each incoming invalidation address to an L1 D-cache line and drops a request that repeats the most recently queued line. It buffers up to `Depth` distinct lines, so Ara's AXI write path is not stalled while Ariane's cache drains invalidations.

## Interface
- `AddrWidth`, 64, address width; matches `AxiAddrWidth`.
- `L1LineWidth`, 16, L1 D-cache line size in bytes (`DCACHE_LINE_WIDTH/8`); power of two, ≥1.
- `Depth`, 4, FIFO entries; power of two, ≥2.
- `CntWidth`, 16, width of the drop counter.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `en_i`  in  1  coherence enable (`acc_cons_en`); 0 = accept and discard all input.
- `inval_addr_i`  in  AddrWidth  invalidation byte address from the filter.
- `inval_valid_i`  in  1  input valid.
- `inval_ready_o`  out  1  input ready.
- `inval_addr_o`  out  AddrWidth  line-aligned address to the core.
- `inval_valid_o`  out  1  output valid.
- `inval_ready_i`  in  1  core accepts the invalidation.
- `empty_o`  out  1  queue holds no entries.
- `drop_cnt_o`  out  CntWidth  saturating count of duplicate drops.

## Operation
- Line address: `line(a)` = `a` with the low `log2(L1LineWidth)` bits forced to 0. Only line addresses are stored.
- Storage: circular buffer with `Depth` entries. `wr_ptr`, `rd_ptr` are `log2(Depth)` bits and wrap naturally. A `count` of `log2(Depth)+1` bits holds 0..Depth.
- Pop: fires when `inval_valid_o && inval_ready_i`. `rd_ptr++`, `count--`.
- Tail register: `last_line` plus `last_vld`.
  - `last_vld` is set on every enqueue.
  - `last_vld` is cleared when the queue drains to 0 (pop with `count==1` and no push).
- Hit: `hit = last_vld && line(inval_addr_i)==last_line && !(count==1 && pop)`. The tail line must still be resident after this cycle.
- Input handshake, combinational from state and inputs only (no path from `inval_ready_i`):
  - `en_i=0`: `inval_ready_o=1`. The transfer is discarded; nothing is enqueued and `drop_cnt_o` is unchanged.
  - `en_i=1`: `inval_ready_o = (count<Depth) || hit`.
- On an accepted transfer with `en_i=1`:
  - `hit=1`: drop it and increment `drop_cnt_o`, saturating at all-ones.
  - `hit=0`: write `line(addr)` at `wr_ptr`, then `wr_ptr++`, `count++`, `last_line<=line(addr)`.
- Push and pop in the same cycle: both take effect and `count` is unchanged. With `count==Depth`, a non-hit push is not accepted even if a pop occurs that cycle (no pass-through).
- Only tail comparison is performed. A repeat of an older, non-tail entry is enqueued again.
- `en_i` affects the input side only. Queued entries always drain.
- Outputs:
  - `inval_valid_o = (count!=0)`.
  - `inval_addr_o` = entry at `rd_ptr`.
  - `empty_o = (count==0)`.
  - `inval_addr_o` is don't-care when not valid; it is 0 after reset.

## Timing
- Reset values:
  - `count=0`, pointers 0, `last_vld=0`, `drop_cnt_o=0`.
  - `inval_valid_o=0`, `inval_addr_o=0`, `empty_o=1`, `inval_ready_o=1`.
- Latency: an address accepted at edge N is presented on `inval_addr_o` with `inval_valid_o=1` from cycle N+1. There is no same-cycle bypass.
- Throughput: 1 push and 1 pop per cycle sustained.
- Output stability: once `inval_valid_o=1`, `inval_addr_o` holds until the pop (AXI-style stability).
- Full: `inval_ready_o` drops in the cycle after the `Depth`-th distinct push. It rises in the cycle after a pop, or combinationally when a hit is presented.
- Reset asserted mid-operation: all entries are lost immediately and outputs take their reset values asynchronously. No invalidation is emitted after the deassertion edge until a new push.

## Test plan
- Basic latency: reset, `en_i=1`, push `0x1234` at cycle 0 with `inval_ready_i=1`.
  -> Cycle 1: `inval_valid_o=1`, `inval_addr_o=0x1230`.
  -> Cycle 2: `empty_o=1`.
- Tail dedup: `inval_ready_i=0`, push `0x1000`, `0x1008`, `0x100F` back-to-back.
  -> One entry `0x1000`, `drop_cnt_o=2`, `inval_ready_o` stays 1 throughout.
- Full with hit: `inval_ready_i=0`, push `0x00`, `0x10`, `0x20`, `0x30`.
  -> Present `0x40`: `inval_ready_o=0`.
  -> Present `0x38`: `inval_ready_o=1`, dropped, `drop_cnt_o` increments.
  -> Then pop one, push `0x40`: output order `0x00`, `0x10`, `0x20`, `0x30`, `0x40`.
- Non-tail repeat and drain corner:
  -> Push `0x10`, `0x20`, `0x10`: three entries, `drop_cnt_o=0`.
  -> With `count==1` holding `0x50`, pop and push `0x54` in the same cycle: `0x50` is enqueued again.
- Disable: `en_i=0`, push `0x500` with 2 entries queued.
  -> `inval_ready_o=1`, queue drains only the 2 entries, `drop_cnt_o` unchanged.
- Reset mid-op: 3 entries queued, pulse `rst_ni` low asynchronously.
  -> `inval_valid_o=0` immediately, `empty_o=1`, `drop_cnt_o=0`, no stale output after release.
  -> Drop-counter saturation: force `CntWidth=2`, 5 duplicate pushes -> `drop_cnt_o=3`.
